// File: rtl/serial_frame_deserializer.sv
// Framed serial receiver: start bit, WIDTH data bits, optional parity, stop bit.
// Each good word is held on dout under a valid/ready handshake until it is consumed.
`timescale 1ns/1ps

module serial_frame_deserializer #(
   parameter int WIDTH      = 8,
   parameter int PARITY_EN  = 1,
   parameter int ODD_PARITY = 0,
   parameter int LSB_FIRST  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             parity_err,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] DATA      = 3'd1;
   localparam logic [2:0] PARITY    = 3'd2;
   localparam logic [2:0] STOP      = 3'd3;
   localparam logic [2:0] WAIT_HIGH = 3'd4;

   localparam logic PEN = (PARITY_EN != 0);
   localparam logic ODD = (ODD_PARITY != 0);

   logic [2:0]       state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shnext;
   logic [CW-1:0]    bitcnt;
   logic             pend_perr;
   logic             last_bit;
   logic             take;
   logic             can_load;

   assign last_bit = (bitcnt == CW'(WIDTH - 1));
   assign take     = dout_valid & dout_ready;
   // The output slot counts as free if the held word is leaving on this same edge.
   assign can_load = ~dout_valid | dout_ready;
   assign busy     = (state != IDLE);

   generate
      if (LSB_FIRST != 0) begin : g_lsb
         assign shnext = {din, shreg[WIDTH-1:1]};
      end else begin : g_msb
         assign shnext = {shreg[WIDTH-2:0], din};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         shreg      <= '0;
         bitcnt     <= '0;
         pend_perr  <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (take) begin
            dout_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (!din) begin
                  state     <= DATA;
                  bitcnt    <= '0;
                  pend_perr <= 1'b0;
               end
            end
            DATA: begin
               shreg  <= shnext;
               bitcnt <= bitcnt + CW'(1);
               if (last_bit) begin
                  state <= PEN ? PARITY : STOP;
               end
            end
            PARITY: begin
               pend_perr <= (^shreg) ^ din ^ ODD;
               state     <= STOP;
            end
            STOP: begin
               if (din) begin
                  if (can_load) begin
                     dout       <= shreg;
                     parity_err <= PEN & pend_perr;
                     dout_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
                  state <= IDLE;
               end else begin
                  frame_err <= 1'b1;
                  state     <= WAIT_HIGH;
               end
            end
            // A held-low line (break) must return high before a new start bit counts.
            WAIT_HIGH: begin
               if (din) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer: nominal, parity, frame error, overrun,
// mid-frame reset and back-to-back frames, with an MSB-first instance sharing the line.
`timescale 1ns/1ps

module tb_serial_frame_deserializer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       din = 1'b1;
   logic       dout_ready = 1'b0;
   logic [7:0] dout, dout_m;
   logic       dout_valid, parity_err, frame_err, overrun, busy;
   logic       dout_valid_m, parity_err_m, frame_err_m, overrun_m, busy_m;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   serial_frame_deserializer #(.WIDTH(8), .PARITY_EN(1), .ODD_PARITY(0), .LSB_FIRST(1)) dut (
      .clk(clk), .rst(rst), .din(din), .dout(dout), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .parity_err(parity_err), .frame_err(frame_err),
      .overrun(overrun), .busy(busy)
   );

   serial_frame_deserializer #(.WIDTH(8), .PARITY_EN(1), .ODD_PARITY(0), .LSB_FIRST(0)) dut_msb (
      .clk(clk), .rst(rst), .din(din), .dout(dout_m), .dout_valid(dout_valid_m),
      .dout_ready(dout_ready), .parity_err(parity_err_m), .frame_err(frame_err_m),
      .overrun(overrun_m), .busy(busy_m)
   );

   always #5 clk = ~clk;

   // Inputs change 1 ns after a rising edge; outputs are read at the same point.
   task send_bit(input logic b);
      din = b;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task send_frame(input logic [7:0] data, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(data[i]);
      send_bit(par);
      send_bit(stop);
   endtask

   task test_reset;
      rst = 1'b0; din = 1'b1; dout_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (dout !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_dout got %h exp 00", dout); end
      vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b exp 0", dout_valid); end
      vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_perr got %b exp 0", parity_err); end
      vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ferr got %b exp 0", frame_err); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovr got %b exp 0", overrun); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
      rst = 1'b1;
      send_bit(1'b1);
   endtask

   task test_nominal;
      logic [7:0] d;
      d = 8'hA5;
      dout_ready = 1'b1;
      send_bit(1'b0);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL nom_busy_start got %b exp 1", busy); end
      for (int i = 0; i < 8; i++) begin
         send_bit(d[i]);
         vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL nom_busy_bit%0d got %b exp 1", i, busy); end
         vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL nom_early_valid%0d got %b exp 0", i, dout_valid); end
      end
      send_bit(1'b0);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL nom_busy_par got %b exp 1", busy); end
      send_bit(1'b1);
      vectors++; if (dout !== 8'hA5) begin miscompares++; $display("[TB] FAIL nom_dout got %h exp a5", dout); end
      vectors++; if (dout_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL nom_valid got %b exp 1", dout_valid); end
      vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("[TB] FAIL nom_perr got %b exp 0", parity_err); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL nom_busy_end got %b exp 0", busy); end
      send_bit(1'b1);
      vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL nom_consumed got %b exp 0", dout_valid); end
   endtask

   task test_parity_err;
      dout_ready = 1'b0;
      send_frame(8'h3C, 1'b1, 1'b1);
      vectors++; if (dout !== 8'h3C) begin miscompares++; $display("[TB] FAIL par_dout got %h exp 3c", dout); end
      vectors++; if (parity_err !== 1'b1) begin miscompares++; $display("[TB] FAIL par_perr got %b exp 1", parity_err); end
      vectors++; if (dout_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL par_valid got %b exp 1", dout_valid); end
      vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL par_ferr got %b exp 0", frame_err); end
      send_bit(1'b1);
      vectors++; if (dout_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL par_hold got %b exp 1", dout_valid); end
      dout_ready = 1'b1;
      send_bit(1'b1);
      dout_ready = 1'b0;
      vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL par_consumed got %b exp 0", dout_valid); end
   endtask

   task test_frame_err;
      send_frame(8'h55, 1'b0, 1'b0);
      vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("[TB] FAIL fe_pulse got %b exp 1", frame_err); end
      vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL fe_valid got %b exp 0", dout_valid); end
      vectors++; if (dout !== 8'h3C) begin miscompares++; $display("[TB] FAIL fe_dout_kept got %h exp 3c", dout); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL fe_busy got %b exp 1", busy); end
      for (int i = 0; i < 5; i++) begin
         send_bit(1'b0);
         vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL fe_once%0d got %b exp 0", i, frame_err); end
         vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL fe_break_busy%0d got %b exp 1", i, busy); end
      end
      send_bit(1'b1);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL fe_idle got %b exp 0", busy); end
      send_frame(8'h0F, 1'b0, 1'b1);
      vectors++; if (dout !== 8'h0F) begin miscompares++; $display("[TB] FAIL fe_next_dout got %h exp 0f", dout); end
      vectors++; if (dout_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL fe_next_valid got %b exp 1", dout_valid); end
      vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("[TB] FAIL fe_next_perr got %b exp 0", parity_err); end
      dout_ready = 1'b1;
      send_bit(1'b1);
      dout_ready = 1'b0;
   endtask

   task test_overrun;
      dout_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1);
      vectors++; if (dout !== 8'h11) begin miscompares++; $display("[TB] FAIL ovr_first_dout got %h exp 11", dout); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_first_pulse got %b exp 0", overrun); end
      send_frame(8'h22, 1'b0, 1'b1);
      vectors++; if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_pulse got %b exp 1", overrun); end
      vectors++; if (dout !== 8'h11) begin miscompares++; $display("[TB] FAIL ovr_dout_held got %h exp 11", dout); end
      vectors++; if (dout_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_valid got %b exp 1", dout_valid); end
      dout_ready = 1'b1;
      send_bit(1'b1);
      dout_ready = 1'b0;
      vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_consumed got %b exp 0", dout_valid); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_one_cycle got %b exp 0", overrun); end
   endtask

   task test_reset_midframe;
      logic [7:0] d;
      d = 8'h5A;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      din = 1'b1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b1;
      vectors++; if (dout !== 8'h00) begin miscompares++; $display("[TB] FAIL rmf_dout got %h exp 00", dout); end
      vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rmf_valid got %b exp 0", dout_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rmf_busy got %b exp 0", busy); end
      vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rmf_perr got %b exp 0", parity_err); end
      send_bit(1'b1);
      vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rmf_no_partial got %b exp 0", dout_valid); end
      send_frame(8'h5A, 1'b0, 1'b1);
      vectors++; if (dout !== 8'h5A) begin miscompares++; $display("[TB] FAIL rmf_next_dout got %h exp 5a", dout); end
      vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rmf_next_perr got %b exp 0", parity_err); end
      vectors++; if (dout_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rmf_next_valid got %b exp 1", dout_valid); end
   endtask

   task test_back_to_back;
      logic [7:0] d;
      int c1, c2;
      d = 8'hFF;
      dout_ready = 1'b1;
      send_bit(1'b1);
      send_frame(8'h01, 1'b1, 1'b1);
      c1 = cyc;
      vectors++; if (dout !== 8'h01) begin miscompares++; $display("[TB] FAIL b2b_first_dout got %h exp 01", dout); end
      vectors++; if (dout_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_first_valid got %b exp 1", dout_valid); end
      vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_first_perr got %b exp 0", parity_err); end
      vectors++; if (dout_m !== 8'h80) begin miscompares++; $display("[TB] FAIL b2b_msb_dout got %h exp 80", dout_m); end
      vectors++; if (dout_valid_m !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_msb_valid got %b exp 1", dout_valid_m); end
      send_bit(1'b0);
      vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_gap_valid got %b exp 0", dout_valid); end
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(1'b0);
      send_bit(1'b1);
      c2 = cyc;
      vectors++; if (dout !== 8'hFF) begin miscompares++; $display("[TB] FAIL b2b_second_dout got %h exp ff", dout); end
      vectors++; if (dout_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_second_valid got %b exp 1", dout_valid); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_overrun got %b exp 0", overrun); end
      vectors++; if ((c2 - c1) !== 11) begin miscompares++; $display("[TB] FAIL b2b_spacing got %0d exp 11", c2 - c1); end
      send_bit(1'b1);
      dout_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cycle %0d exp finish", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_nominal();
      test_parity_err();
      test_frame_err();
      test_overrun();
      test_reset_midframe();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_frame_deserializer.md
Name: serial_frame_deserializer

Overview:
- Receives a framed serial bitstream, one bit per clk, from a shift-register serial output stage.
- Detects the start bit, shifts in WIDTH data bits, and checks optional parity and the stop bit.
- Presents each good word on a parallel output held by a valid/ready handshake, so the parallel word crosses to the consuming logic.

Parameters:
- WIDTH, 8, data bits per frame (2..32).
- PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- ODD_PARITY, 0, 0 = even parity (total ones in data plus parity is even); 1 = odd parity.
- LSB_FIRST, 1, 1 = first data bit received is dout[0]; 0 = first data bit received is dout[WIDTH-1].

Ports:
- clk, input, 1, rising-edge clock, the only clock.
- rst, input, 1, synchronous active-low reset (sampled on the clk rising edge; 0 = reset).
- din, input, 1, serial line; idles at 1.
- dout, output, WIDTH, received word.
- dout_valid, output, 1, dout holds an unconsumed word.
- dout_ready, input, 1, consumer accepts the word; transfer happens when dout_valid and dout_ready are both 1 on a clk edge.
- parity_err, output, 1, parity mismatch flag for the current dout; meaningful only while dout_valid=1; 0 when PARITY_EN=0.
- frame_err, output, 1, one-cycle pulse when the stop bit is sampled as 0.
- overrun, output, 1, one-cycle pulse when a good frame is dropped because the output register is occupied.
- busy, output, 1, 1 whenever the state is not IDLE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state goes to IDLE; shift register, bit counter, dout, dout_valid, parity_err, frame_err, overrun and busy all go to 0.
  - Reset mid-frame discards the partial frame; no output is produced for it.
- States: IDLE, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - din=0 sampled: go to DATA and clear the bit counter.
  - din=1: stay in IDLE.
- DATA:
  - Each cycle, shift din in (in the direction set by LSB_FIRST) and increment the counter.
  - After WIDTH bits: go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: sample one bit, compute the mismatch against the data XOR (inverted when ODD_PARITY=1), go to STOP.
- STOP, din=1 (good frame):
  - If the output register is free, or is being transferred in this same cycle: load dout and parity_err, set dout_valid=1 from the next cycle.
  - Otherwise: keep the old dout and parity_err, pulse overrun for one cycle, drop the new word.
  - Next state IDLE.
- STOP, din=0:
  - Pulse frame_err for one cycle; do not load or set valid; go to WAIT_HIGH.
- WAIT_HIGH: stay until din=1 is sampled, then go to IDLE. This prevents a break condition from being decoded as a new start bit.
- Timing (PARITY_EN=1, start bit sampled at edge 0):
  - Data bits are sampled at edges 1..WIDTH, parity at WIDTH+1, stop at WIDTH+2.
  - dout_valid is visible after edge WIDTH+2.
  - Minimum frame length is WIDTH+3 clocks (WIDTH+2 with PARITY_EN=0).
  - Back-to-back frames with no idle gap are supported: the start bit may be sampled in the cycle immediately after the stop bit.
- Handshake:
  - dout_valid stays 1 and dout/parity_err stay stable until the transfer.
  - On transfer with no simultaneous load, dout_valid goes to 0 on the next cycle.
  - Simultaneous transfer and good-frame load: dout updates to the new word and dout_valid stays 1.
- dout_ready has no effect while dout_valid=0.
- Only good frames affect dout, dout_valid and parity_err; frame_err and overrun never change dout.

Test Plan:
- Nominal: WIDTH=8, even parity, LSB first, dout_ready=1. Send start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1 -> dout=0xA5, parity_err=0, dout_valid=1 after edge 10, busy=1 from edge 0 through 10.
- Parity error: send 0x3C with parity bit 1 -> dout=0x3C, parity_err=1, dout_valid=1, frame_err=0.
- Frame error: send 0x55 with stop bit 0, hold din=0 for 5 more cycles, then 1 -> frame_err pulses once, dout_valid stays 0, busy stays 1 until din=1 is sampled, then an immediate new frame of 0x0F is received correctly.
- Overrun: dout_ready=0; send 0x11 then 0x22 back-to-back -> dout=0x11 held, overrun pulses at the 0x22 stop edge. Then dout_ready=1 for one cycle -> dout_valid=0 on the next cycle.
- Reset mid-frame: drive rst=0 for one edge after 4 data bits -> all outputs 0, busy=0. Next frame 0x5A -> dout=0x5A, parity_err=0.
- Back-to-back with handshake: dout_ready=1, frames 0x01 then 0xFF with no gap -> two accepted words, valid rising edges 11 cycles apart, no overrun. Repeat with LSB_FIRST=0 on the 0x01 bit pattern -> dout=0x80.
